// File: rtl/kvs_arb_pkg.sv
// Shared types, widths and packed-field layout for the KVS kernel command arbiter.
package kvs_arb_pkg;

  localparam int KVS_CMD_W = 300;
  localparam int KVS_RSP_W = 330;

  // Command layout
  localparam int CMD_KEY_LSB  = 0;
  localparam int CMD_KEY_W    = 128;
  localparam int CMD_VAL_LSB  = 128;
  localparam int CMD_VAL_W    = 32;
  localparam int CMD_OP_LSB   = 160;
  localparam int CMD_OP_W     = 5;
  localparam int CMD_PRI_LSB  = 165;
  localparam int CMD_PRI_W    = 7;
  localparam int CMD_MASK_LSB = 172;
  localparam int CMD_MASK_W   = 128;

  // Opcode bits inside the opcode field: {update, search, read, write, erase}
  localparam int OP_ERASE  = 0;
  localparam int OP_WRITE  = 1;
  localparam int OP_READ   = 2;
  localparam int OP_SEARCH = 3;
  localparam int OP_UPDATE = 4;

  // Response layout; bits above RSP_ENT_FULL are reserved
  localparam int RSP_KEY_LSB    = 0;
  localparam int RSP_VAL_LSB    = 128;
  localparam int RSP_MASK_LSB   = 160;
  localparam int RSP_PRI_LSB    = 288;
  localparam int RSP_SINGLE_HIT = 295;
  localparam int RSP_MULTI_HIT  = 296;
  localparam int RSP_ENT_ERR    = 297;
  localparam int RSP_ENT_FULL   = 298;

  typedef enum logic {
    S_WAIT_READY = 1'b0,
    S_RUN        = 1'b1
  } kvs_arb_state_t;

  function automatic logic op_is_onehot(input logic [CMD_OP_W-1:0] op);
    return (op != '0) && ((op & (op - CMD_OP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/kvs_cmd_arbiter_if.sv
// Requester-side and kernel-side signal bundle of the KVS command arbiter.
interface kvs_cmd_arbiter_if
  import kvs_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CMD_W           = KVS_CMD_W,
  parameter int RSP_W           = KVS_RSP_W
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*CMD_W-1:0] req_cmd;
  logic                     kvs_ready;
  logic                     kvs_cmd_full;
  logic                     kvs_cmd_valid;
  logic [CMD_W-1:0]         kvs_cmd;
  logic                     kvs_init;
  logic                     kvs_ack;
  logic [RSP_W-1:0]         kvs_rsp;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [RSP_W-1:0]         rsp_data;
  logic [CNT_W-1:0]         outstanding;
  logic                     err_orphan_ack;
  logic                     err_bad_cmd;

  // Arbiter view
  modport slave (
    input  req_valid, req_cmd, kvs_ready, kvs_cmd_full, kvs_ack, kvs_rsp,
    output req_ready, kvs_cmd_valid, kvs_cmd, kvs_init, rsp_valid, rsp_data,
           outstanding, err_orphan_ack, err_bad_cmd
  );

  // Requesters plus kernel view
  modport master (
    output req_valid, req_cmd, kvs_ready, kvs_cmd_full, kvs_ack, kvs_rsp,
    input  req_ready, kvs_cmd_valid, kvs_cmd, kvs_init, rsp_valid, rsp_data,
           outstanding, err_orphan_ack, err_bad_cmd
  );

endinterface

// File: rtl/kvs_tag_fifo.sv
// In-order tag store: remembers which requester issued each in-flight kernel command.
module kvs_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so push-when-full succeeds alongside it.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: the storage array is not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kvs_cmd_arbiter.sv
// Round-robin arbiter sharing one axonerve KVS kernel command port among NUM_REQ requesters,
// with kernel flow control and in-order routing of acknowledges back to the issuer.
module kvs_cmd_arbiter
  import kvs_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CMD_W           = KVS_CMD_W,
  parameter int RSP_W           = KVS_RSP_W
) (
  input  logic             aclk,
  input  logic             areset,
  kvs_cmd_arbiter_if.slave bus
);
  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  kvs_arb_state_t     state_q, state_d;
  logic               can_issue;
  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   grant_idx;
  logic               grant_found;
  logic [CMD_W-1:0]   grant_cmd;
  logic [NUM_REQ-1:0] ready_vec;
  logic               handshake;
  logic               cmd_ok;
  logic               tag_pop;
  logic [TAG_W-1:0]   tag_head;
  logic [CNT_W-1:0]   tag_count;
  logic               tag_empty;
  logic [NUM_REQ-1:0] head_onehot;

  always_ff @(posedge aclk) begin
    if (areset) state_q <= S_WAIT_READY;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    can_issue = 1'b0;
    case (state_q)
      S_WAIT_READY: if (bus.kvs_ready) state_d = S_RUN;
      S_RUN: begin
        if (!bus.kvs_ready) state_d = S_WAIT_READY;
        can_issue = !bus.kvs_cmd_full && (tag_count < CNT_W'(MAX_OUTSTANDING));
      end
      default: state_d = S_WAIT_READY;
    endcase
  end

  // First valid requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin : rr_search
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && bus.req_valid[TAG_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_W'(cand);
      end
    end
  end

  always_comb begin
    grant_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == TAG_W'(i)) grant_cmd = bus.req_cmd[i*CMD_W +: CMD_W];
    end
  end

  always_comb begin
    ready_vec = '0;
    if (can_issue && grant_found) ready_vec[grant_idx] = 1'b1;
  end

  assign bus.req_ready = ready_vec;
  assign handshake     = can_issue && grant_found;
  assign cmd_ok        = op_is_onehot(grant_cmd[CMD_OP_LSB +: CMD_OP_W]);
  assign bus.kvs_init  = 1'b0;

  // Malformed opcodes still complete the handshake so the requester never stalls on them.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr            <= '0;
      bus.kvs_cmd_valid <= 1'b0;
      bus.kvs_cmd       <= '0;
      bus.err_bad_cmd   <= 1'b0;
    end else begin
      bus.kvs_cmd_valid <= handshake && cmd_ok;
      if (handshake) begin
        rr_ptr <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
        if (cmd_ok) bus.kvs_cmd     <= grant_cmd;
        else        bus.err_bad_cmd <= 1'b1;
      end
    end
  end

  kvs_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (TAG_W)
  ) u_tag_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .push      (handshake && cmd_ok),
    .push_data (grant_idx),
    .pop       (tag_pop),
    .head      (tag_head),
    .count     (tag_count),
    .empty     (tag_empty)
  );

  assign tag_pop         = bus.kvs_ack && !tag_empty;
  assign bus.outstanding = tag_count;

  always_comb begin
    head_onehot           = '0;
    head_onehot[tag_head] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      bus.rsp_valid      <= '0;
      bus.rsp_data       <= '0;
      bus.err_orphan_ack <= 1'b0;
    end else begin
      bus.rsp_valid <= tag_pop ? head_onehot : '0;
      if (tag_pop) bus.rsp_data <= bus.kvs_rsp;
      if (bus.kvs_ack && tag_empty) bus.err_orphan_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kvs_cmd_arbiter.sv
// Randomized and directed bench for kvs_cmd_arbiter against a queue-based reference model.
module tb_kvs_cmd_arbiter;
  import kvs_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int MAX_OUT = 16;
  localparam int CMD_W   = KVS_CMD_W;
  localparam int RSP_W   = KVS_RSP_W;

  logic aclk;
  logic areset;

  kvs_cmd_arbiter_if #(
    .NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT), .CMD_W(CMD_W), .RSP_W(RSP_W)
  ) bus ();

  kvs_cmd_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT), .CMD_W(CMD_W), .RSP_W(RSP_W)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit                 m_run;
  int                 m_rr;
  int                 m_tags[$];
  bit                 m_err_bad;
  bit                 m_err_orph;
  bit                 m_cmd_valid;
  logic [CMD_W-1:0]   m_cmd;
  logic [NUM_REQ-1:0] m_rsp_valid;
  logic [RSP_W-1:0]   m_rsp_data;
  bit                 allow_bad;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand_bits();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [CMD_W-1:0] new_cmd(input bit bad_ok);
    logic [CMD_W-1:0] c;
    c = CMD_W'(rand_bits());
    if (bad_ok && $urandom_range(0, 7) == 0) c[CMD_OP_LSB +: CMD_OP_W] = 5'($urandom);
    else c[CMD_OP_LSB +: CMD_OP_W] = 5'b00001 << $urandom_range(0, 4);
    return c;
  endfunction

  // One clock cycle: drive inputs, check the combinational grant, advance the model, check registers.
  task automatic cycle(input logic [NUM_REQ-1:0] v, input bit rdy, input bit full, input bit ack);
    logic [NUM_REQ-1:0] exp_ready;
    logic [CMD_W-1:0]   c;
    int                 g;
    int                 t;
    bit                 hs;
    bus.req_valid    = v;
    bus.kvs_ready    = rdy;
    bus.kvs_cmd_full = full;
    bus.kvs_ack      = ack;
    bus.kvs_rsp      = RSP_W'(rand_bits());
    #2;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (m_rr + k) % NUM_REQ;
      if (g < 0 && v[idx]) g = idx;
    end
    hs        = m_run && !full && (m_tags.size() < MAX_OUT) && (g >= 0);
    exp_ready = '0;
    if (hs) exp_ready[g] = 1'b1;
    check("req_ready", bus.req_ready, exp_ready);

    m_cmd_valid = 0;
    if (hs) begin
      c    = bus.req_cmd[g*CMD_W +: CMD_W];
      m_rr = (g + 1) % NUM_REQ;
      if ($countones(c[CMD_OP_LSB +: CMD_OP_W]) == 1) begin
        m_cmd_valid = 1;
        m_cmd       = c;
      end else begin
        m_err_bad = 1;
      end
    end
    m_rsp_valid = '0;
    if (ack) begin
      if (m_tags.size() > 0) begin
        t              = m_tags.pop_front();
        m_rsp_valid[t] = 1'b1;
        m_rsp_data     = bus.kvs_rsp;
      end else begin
        m_err_orph = 1;
      end
    end
    if (m_cmd_valid) m_tags.push_back(g);
    m_run = rdy;

    @(posedge aclk);
    #1;
    check("kvs_cmd_valid", bus.kvs_cmd_valid, m_cmd_valid);
    if (m_cmd_valid) check("kvs_cmd", bus.kvs_cmd, m_cmd);
    check("rsp_valid", bus.rsp_valid, m_rsp_valid);
    if (m_rsp_valid != '0) check("rsp_data", bus.rsp_data, m_rsp_data);
    check("outstanding", bus.outstanding, m_tags.size());
    check("err_bad_cmd", bus.err_bad_cmd, m_err_bad);
    check("err_orphan_ack", bus.err_orphan_ack, m_err_orph);
    check("kvs_init", bus.kvs_init, 1'b0);
    if (hs) bus.req_cmd[g*CMD_W +: CMD_W] = new_cmd(allow_bad);
  endtask

  task automatic do_reset();
    areset           = 1'b1;
    bus.req_valid    = '0;
    bus.kvs_ready    = 1'b0;
    bus.kvs_cmd_full = 1'b0;
    bus.kvs_ack      = 1'b0;
    bus.kvs_rsp      = '0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_req_ready", bus.req_ready, '0);
    check("rst_kvs_cmd_valid", bus.kvs_cmd_valid, 1'b0);
    check("rst_kvs_cmd", bus.kvs_cmd, '0);
    check("rst_rsp_valid", bus.rsp_valid, '0);
    check("rst_rsp_data", bus.rsp_data, '0);
    check("rst_outstanding", bus.outstanding, '0);
    check("rst_err_bad_cmd", bus.err_bad_cmd, 1'b0);
    check("rst_err_orphan_ack", bus.err_orphan_ack, 1'b0);
    areset     = 1'b0;
    m_run      = 0;
    m_rr       = 0;
    m_tags.delete();
    m_err_bad  = 0;
    m_err_orph = 0;
  endtask

  initial begin
    int ack_pct;
    allow_bad = 0;
    areset    = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) bus.req_cmd[i*CMD_W +: CMD_W] = new_cmd(0);

    // Kernel not ready: no grant until the cycle after kvs_ready rises
    do_reset();
    repeat (3) cycle(4'b0001, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(4'b0001, 1'b1, 1'b0, 1'b0);

    // Round robin over all requesters, then in-order ack routing
    do_reset();
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (5) cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(4'b0000, 1'b1, 1'b0, 1'b1);

    // Outstanding limit: an ack in the same cycle does not relax it
    do_reset();
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (20) cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    repeat (3) cycle(4'b1111, 1'b1, 1'b0, 1'b0);

    // Reset forgets in-flight commands; a later ack is an orphan
    do_reset();
    cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0, 1'b0);

    // Ack coincident with a handshake at outstanding=5
    do_reset();
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (5) cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);

    // Non-one-hot opcode from requester 2 is accepted and dropped
    bus.req_cmd[2*CMD_W + CMD_OP_LSB +: CMD_OP_W] = 5'b00110;
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);

    // Kernel full mid-stream stops issue immediately while acks keep draining
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(4'b1111, 1'b1, 1'b1, 1'b1);
    repeat (2) cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with varying ack pressure and occasional bad opcodes
    do_reset();
    allow_bad = 1;
    for (int ph = 0; ph < 8; ph++) begin
      ack_pct = (ph % 4) * 30;
      for (int n = 0; n < 250; n++) begin
        cycle(NUM_REQ'($urandom),
              $urandom_range(0, 19) != 0,
              $urandom_range(0, 7) == 0,
              (m_tags.size() > 0) ? ($urandom_range(0, 99) < ack_pct)
                                  : ($urandom_range(0, 63) == 0));
      end
      if (ph == 3) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kvs_cmd_arbiter.md
Name: kvs_cmd_arbiter

Overview:
- Shares the single axonerve KVS kernel command port between NUM_REQ independent requesters (host stream channels).
- Round-robin arbitration, flow control against the kernel command FIFO, and in-order tag tracking.
- Routes each kernel acknowledge back to the requester that issued the command.
- Sits between per-channel stream-to-command decoders and the kernel instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_OUTSTANDING, 16, maximum commands issued but not yet acknowledged (power of 2).
- CMD_W, 300, packed command width (kvs_arb_pkg::KVS_CMD_W).
- RSP_W, 330, packed response width (kvs_arb_pkg::KVS_RSP_W).

Ports:
- aclk, in, 1, sole clock.
- areset, in, 1, synchronous active-high reset.
- req_valid, in, NUM_REQ, per-requester command valid.
- req_ready, out, NUM_REQ, per-requester command accept.
- req_cmd, in, NUM_REQ*CMD_W, packed commands; requester i occupies bits [i*CMD_W +: CMD_W].
- kvs_ready, in, 1, kernel O_READY.
- kvs_cmd_full, in, 1, kernel O_CMD_FULL.
- kvs_cmd_valid, out, 1, to kernel I_CMD_VALID.
- kvs_cmd, out, CMD_W, packed command to kernel.
- kvs_ack, in, 1, kernel O_ACK.
- kvs_rsp, in, RSP_W, packed kernel result fields.
- rsp_valid, out, NUM_REQ, one-hot response strobe.
- rsp_data, out, RSP_W, registered response, shared by all requesters.
- outstanding, out, $clog2(MAX_OUTSTANDING)+1, commands in flight.
- err_orphan_ack, out, 1, sticky: ack received with no tag.
- err_bad_cmd, out, 1, sticky: opcode field not one-hot.

Behaviour:
- Reset (areset=1 at an aclk edge):
  - All outputs go to 0; FSM enters S_WAIT_READY; RR pointer=0; tag FIFO emptied; sticky errors cleared.
  - In-flight commands are forgotten; later acks count as orphans.
- FSM:
  - S_WAIT_READY -> S_RUN when kvs_ready=1.
  - S_RUN -> S_WAIT_READY when kvs_ready=0.
  - Issue happens only in S_RUN. Ack routing is active in both states.
- can_issue = S_RUN & ~kvs_cmd_full & (outstanding < MAX_OUTSTANDING). An ack in the same cycle does not relax this limit.
- Arbitration:
  - Grant goes to the first i with req_valid[i], searching from the RR pointer upward modulo NUM_REQ.
  - req_ready is combinational: one-hot at the granted index when can_issue, else all zero.
  - On handshake from requester i, the pointer becomes (i+1) mod NUM_REQ; otherwise it holds.
- Issue:
  - kvs_cmd_valid and kvs_cmd are registered: they assert on the cycle after the handshake, for exactly 1 cycle.
  - The tag (requester index) is pushed into the tag FIFO on that same cycle.
  - Back-to-back issue at 1 command/cycle is allowed.
  - The kernel asserts full with at least 2 entries of margin, which covers the 1-cycle registration.
- Opcode check:
  - Opcode = {update, search, read, write, erase}.
  - If it is not one-hot, the command is still accepted (handshake completes) but dropped: no kvs_cmd_valid, no tag push, err_bad_cmd set.
  - The INIT bit is always driven 0 to the kernel.
- Ack routing:
  - On kvs_ack with tag FIFO non-empty: pop the tag t; next cycle rsp_valid[t]=1 for 1 cycle and rsp_data is the registered kvs_rsp.
  - On kvs_ack with tag FIFO empty: no rsp_valid, err_orphan_ack set.
  - Requesters cannot backpressure responses.
- Simultaneous push and pop: outstanding is unchanged; FIFO ordering is preserved, including when full (pop then push).
- Width rules: outstanding saturates by construction; the tag FIFO depth is MAX_OUTSTANDING and the tag width is $clog2(NUM_REQ).

Decomposition:
- kvs_arb_pkg holds:
  - KVS_CMD_W and KVS_RSP_W.
  - Field offsets: key 127:0, value 159:128, opcode 164:160, pri 171:165, mask 299:172.
  - Response layout: key, value, mask, pri, single_hit, multi_hit, ent_err, ent_full.
  - State enum kvs_arb_state_t {S_WAIT_READY, S_RUN}.
- One sub-module: kvs_tag_fifo, a synchronous register FIFO with push, pop, count and empty outputs.

Test Plan:
- Reset, hold kvs_ready=0, assert req_valid=4'b0001 -> req_ready stays 0; raise kvs_ready -> ready on the next cycle, then kvs_cmd_valid 1 cycle after the handshake.
- All 4 requesters hold valid, kernel never full -> grants 0,1,2,3,0 on consecutive cycles; then 4 acks -> rsp_valid 0001, 0010, 0100, 1000 in order.
- MAX_OUTSTANDING=16, no acks -> 16 accepts, then req_ready=0 and outstanding=16; one ack -> exactly one more accept, outstanding back to 16.
- Ack coincident with handshake at outstanding=5 -> outstanding stays 5 and the response routes to the older tag.
- Opcode 5'b00110 from requester 2 -> accepted, no kvs_cmd_valid, err_bad_cmd=1, outstanding unchanged.
- kvs_ack with the FIFO empty -> err_orphan_ack=1, rsp_valid=0; kvs_cmd_full=1 mid-stream -> issue stops the same cycle, pending acks still routed.
